// File: rtl/fetch_queue_if.sv
// Bundle of the fetch-queue control, upstream slot, decode-side and status signals.
// The slave modport is the queue's view; master is the driver/observer side.
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk_en;
  logic          flush;
  logic          in_bubble;
  logic [31:0]   in_pc;
  logic [7:0]    in_exc;
  logic [31:0]   in_inst;
  logic          dec_stall;
  logic          out_bubble;
  logic [31:0]   out_pc;
  logic [31:0]   out_inst;
  logic [7:0]    out_exc;
  logic          fetch_stall;
  logic [CW-1:0] count;
  logic          overflow;

  modport slave (
    input  clk_en, flush, in_bubble, in_pc, in_exc, in_inst, dec_stall,
    output out_bubble, out_pc, out_inst, out_exc, fetch_stall, count, overflow
  );

  modport master (
    output clk_en, flush, in_bubble, in_pc, in_exc, in_inst, dec_stall,
    input  out_bubble, out_pc, out_inst, out_exc, fetch_stall, count, overflow
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue between the second fetch stage and decode: circular buffer
// with separate occupancy count, early fetch back-pressure and a sticky overflow flag.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic [31:0] pc_mem_q   [DEPTH];
  logic [31:0] inst_mem_q [DEPTH];
  logic [7:0]  exc_mem_q  [DEPTH];

  logic active, empty, full, push_req, push, pop;

  assign active   = bus.clk_en && !bus.flush;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign push_req = active && !bus.in_bubble;
  assign pop      = active && !bus.dec_stall && !empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push     = push_req && (!full || pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (bus.clk_en && bus.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
      if (push_req && !push) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      pc_mem_q[wr_ptr_q]   <= bus.in_pc;
      inst_mem_q[wr_ptr_q] <= bus.in_inst;
      exc_mem_q[wr_ptr_q]  <= bus.in_exc;
    end
  end

  assign bus.out_bubble  = empty || bus.flush;
  assign bus.out_pc      = empty ? 32'd0 : pc_mem_q[rd_ptr_q];
  assign bus.out_inst    = empty ? 32'd0 : inst_mem_q[rd_ptr_q];
  assign bus.out_exc     = empty ? 8'd0  : exc_mem_q[rd_ptr_q];
  // Two slots stay free for requests already inside the two-cycle memory pipeline.
  assign bus.fetch_stall = (count_q >= CW'(DEPTH - 2));
  assign bus.count       = count_q;
  assign bus.overflow    = ovf_q;
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries (power of two, 4..16).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port clk_en  input  1  global clock enable; when 0, all state holds.
REQ-005 SHALL have port flush  input  1  discard all queued and incoming instructions (branch/interrupt/rfe redirect).
REQ-006 SHALL have port in_bubble  input  1  upstream (second fetch stage) slot carries no instruction.
REQ-007 SHALL have port in_pc  input  32  PC of the upstream slot.
REQ-008 SHALL have port in_exc  input  8  exception code of the upstream slot (0 = none).
REQ-009 SHALL have port in_inst  input  32  instruction word returned by instruction memory, aligned with the upstream slot.
REQ-010 SHALL have port dec_stall  input  1  decode cannot accept the head entry this cycle.
REQ-011 SHALL have port out_bubble  output  1  no valid entry is presented to decode.
REQ-012 SHALL have port out_pc  output  32  head entry PC.
REQ-013 SHALL have port out_inst  output  32  head entry instruction.
REQ-014 SHALL have port out_exc  output  8  head entry exception code.
REQ-015 SHALL have port fetch_stall  output  1  back-pressure to fetch address generation.
REQ-016 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-017 SHALL have port overflow  output  1  sticky error: a push was attempted while full.

Function
REQ-018 SHALL push {in_pc, in_inst, in_exc} when clk_en=1, rst_n=1, flush=0, in_bubble=0, and count<DEPTH; entries carrying a nonzero in_exc SHALL be pushed like any other.
REQ-019 SHALL pop the head when clk_en=1, rst_n=1, flush=0, dec_stall=0, and count>0.
REQ-020 SHALL make a pushed entry visible at the outputs no earlier than the cycle after the push (1-cycle latency; no empty bypass).
REQ-021 SHALL drive out_pc/out_inst/out_exc combinationally from the head entry, and drive all three to 0 when count=0.
REQ-022 SHALL drive out_bubble = (count==0) || flush.
REQ-023 SHALL, on a simultaneous push and pop, leave count unchanged and advance both pointers.
REQ-024 SHALL use wrap-around read/write pointers of width $clog2(DEPTH), with count tracked separately so that full (count=DEPTH) and empty (count=0) are distinguished.
REQ-025 SHALL drive fetch_stall = (count >= DEPTH-2), combinationally, reserving two slots for the fetch requests already in flight in the two-cycle memory pipeline.
REQ-026 SHALL, when a push is attempted at count=DEPTH without a same-cycle pop, drop the entry and set overflow=1 until reset.
REQ-027 SHALL, on a clk_en=1 edge with flush=1, zero both pointers and count, perform no push and no pop, and leave overflow unchanged.
REQ-028 SHALL hold pointers, count, storage and overflow on any edge with clk_en=0, except as REQ-030 requires.

Reset
REQ-029 SHALL, on a rising clk edge with rst_n=0, set both pointers, count, and overflow to 0, giving out_bubble=1, out_pc=0, out_inst=0, out_exc=0, and fetch_stall=0.
REQ-030 SHALL apply reset regardless of clk_en and flush, with reset having the highest priority; storage contents need not be cleared.
REQ-031 SHALL, on reset mid-operation, discard every queued entry, and SHALL treat the first push after reset as the head at the next cycle.

Verification
REQ-032 Bench SHALL cover this scenario: reset, then push pc=0x400 inst=0x11111111 with dec_stall=0 -> next cycle out_bubble=0, out_pc=0x400, out_inst=0x11111111; one cycle later out_bubble=1.
REQ-033 Bench SHALL cover this scenario: dec_stall=1, push pc=0x400,0x404,0x408,0x40C -> fetch_stall=1 once count=2, count=4; a fifth push sets overflow=1 and count stays 4.
REQ-034 Bench SHALL cover this scenario: count=4, push and pop in the same cycle -> count stays 4, head advances 0x400->0x404, and overflow stays 0.
REQ-035 Bench SHALL cover this scenario: count=3 with flush=1 and a valid push in the same cycle -> out_bubble=1 that cycle; next cycle count=0 and outputs are 0.
REQ-036 Bench SHALL cover this scenario: push pc=0x402 with in_exc=0x84 -> the head shows out_pc=0x402 and out_exc=0x84, and it pops normally.
REQ-037 Bench SHALL cover this scenario: clk_en=0 with pushes and pops requested -> count and head are unchanged; rst_n=0 with clk_en=0 -> count=0 on the next edge.
